// File: rtl/mux_16x1_rr_arbiter.sv
// Round-robin arbiter that owns the select of a 16:1 mux. It holds each grant until release and
// leaves one dead cycle between owners. The optional forced release is enabled by MUX_ARB_TIMEOUT_EN.
module mux_16x1_rr_arbiter #(
  parameter int N_REQ    = 16,
  parameter int SEL_W    = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             done_i,
  output logic [SEL_W-1:0] sel_o,
  output logic [N_REQ-1:0] gnt_o,
  output logic             busy_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             state_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [SEL_W-1:0]   sel_q;
  logic [N_REQ-1:0]   gnt_q;
  logic               busy_q;

  logic               win_valid;
  logic [SEL_W-1:0]   win_idx;
  logic [SEL_W-1:0]   cand;
  logic               release_c;
  logic               timeout_c;

  // Rotating priority search: candidates start just after the last owner and wrap modulo N_REQ.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ptr_q + SEL_W'(k);
      if (!win_valid && req_i[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign release_c = done_i | ~req_i[ptr_q];

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] hold_q;
  logic       to_q;

  // The edge on which the counter would reach MAX_HOLD forces the release; a normal release wins.
  assign timeout_c = (hold_q == 8'(MAX_HOLD - 1)) && !release_c;
  assign timeout_o = to_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
      to_q   <= 1'b0;
    end else begin
      to_q <= 1'b0;
      case (state_q)
        S_IDLE:  hold_q <= '0;
        S_GRANT: begin
          if (release_c || timeout_c) begin
            hold_q <= '0;
            to_q   <= timeout_c;
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: hold_q <= '0;
      endcase
    end
  end
`else
  assign timeout_c = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= {SEL_W{1'b1}};
      sel_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_valid) begin
            state_q <= S_GRANT;
            ptr_q   <= win_idx;
            sel_q   <= win_idx;
            gnt_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            busy_q  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (release_c || timeout_c) begin
            state_q <= S_GAP;
            gnt_q   <= '0;
          end
        end
        S_GAP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel_o  = sel_q;
  assign gnt_o  = gnt_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_mux_16x1_rr_arbiter.sv
// Bench for mux_16x1_rr_arbiter: directed scenarios plus random traffic, all checked against a
// behavioural model of the round-robin rules. MUX_ARB_TIMEOUT_EN selects the forced-release checks.
module tb_mux_16x1_rr_arbiter;

  localparam int HOLD = 4;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [3:0]  sel_o;
  logic [15:0] gnt_o;
  logic        busy_o;
  logic        timeout_o;

  int n_checks;
  int n_errors;
  logic [15:0] exp_q[$];

  // Reference model state: phase 0=idle, 1=owner holds the mux, 2=dead cycle.
  int          m_phase;
  int          m_ptr;
  int          m_hold;
  logic [3:0]  m_sel;
  logic [15:0] m_gnt;
  logic        m_busy;
  logic        m_to;

  mux_16x1_rr_arbiter #(.N_REQ(16), .SEL_W(4), .MAX_HOLD(HOLD)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .done_i   (done),
    .sel_o    (sel_o),
    .gnt_o    (gnt_o),
    .busy_o   (busy_o),
    .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [15:0] rq, input logic d);
    logic rel;
    logic tmo;
    bit   found;
    int   c;
    if (r) begin
      m_phase = 0; m_ptr = 15; m_hold = 0;
      m_sel = 4'd0; m_gnt = 16'd0; m_busy = 1'b0; m_to = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          m_to = 1'b0;
          found = 0;
          for (int k = 1; k <= 16; k++) begin
            c = (m_ptr + k) % 16;
            if (!found && rq[c]) begin
              found = 1;
              m_ptr = c;
            end
          end
          if (found) begin
            m_phase = 1; m_hold = 0;
            m_sel = 4'(m_ptr); m_gnt = 16'd1 << m_ptr; m_busy = 1'b1;
          end
        end
        1: begin
          rel = d || !rq[m_ptr];
          tmo = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
          tmo = !rel && (m_hold + 1 == HOLD);
`endif
          if (rel || tmo) begin
            m_phase = 2; m_gnt = 16'd0; m_to = tmo;
          end else begin
            m_hold++;
          end
        end
        default: begin
          m_phase = 0; m_busy = 1'b0; m_to = 1'b0;
        end
      endcase
    end
  endtask

  // Drive one cycle of inputs, advance the model on the same edge, then compare all outputs.
  task automatic step(input logic r, input logic [15:0] rq, input logic d);
    @(negedge clk);
    rst = r; req = rq; done = d;
    @(posedge clk);
    model_edge(r, rq, d);
    #1;
    chk("sel", 32'(sel_o), 32'(m_sel));
    chk("gnt", 32'(gnt_o), 32'(m_gnt));
    chk("busy", 32'(busy_o), 32'(m_busy));
    chk("timeout", 32'(timeout_o), 32'(m_to));
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    logic [15:0] prev_gnt;
    logic [15:0] rq;
    int          held;
    int          to_cnt;
    n_checks = 0; n_errors = 0;
    rst = 1'b1; req = 16'h0000; done = 1'b0;
    m_phase = 0; m_ptr = 15; m_hold = 0;
    m_sel = 4'd0; m_gnt = 16'd0; m_busy = 1'b0; m_to = 1'b0;

    // Reset with everyone requesting, then the first grant goes to requester 0.
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0);
    chk("t1_rst_gnt", 32'(gnt_o), 32'h0);
    chk("t1_rst_busy", 32'(busy_o), 32'h0);
    step(1'b0, 16'hFFFF, 1'b0);
    chk("t1_first_gnt", 32'(gnt_o), 32'h0001);

    // Single requester 2: grant, done after 3 cycles, gap, re-grant.
    step(1'b1, 16'h0000, 1'b0);
    step(1'b0, 16'h0004, 1'b0);
    chk("t2_gnt", 32'(gnt_o), 32'h0004);
    chk("t2_sel", 32'(sel_o), 32'd2);
    step(1'b0, 16'h0004, 1'b0);
    step(1'b0, 16'h0004, 1'b0);
    step(1'b0, 16'h0004, 1'b1);
    chk("t2_gap_gnt", 32'(gnt_o), 32'h0);
    chk("t2_gap_busy", 32'(busy_o), 32'h1);
    step(1'b0, 16'h0004, 1'b0);
    step(1'b0, 16'h0004, 1'b0);
    chk("t2_regrant", 32'(gnt_o), 32'h0004);

    // Round robin between 0 and 15 from reset; grant order checked through the expected queue.
    step(1'b1, 16'h0000, 1'b0);
    exp_q.push_back(16'h0001); exp_q.push_back(16'h8000);
    exp_q.push_back(16'h0001); exp_q.push_back(16'h8000);
    prev_gnt = 16'h0000;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      step(1'b0, 16'h8001, (gnt_o != 16'h0000));
      if (gnt_o != 16'h0000 && prev_gnt == 16'h0000) chk("t3_order", 32'(gnt_o), 32'(exp_q.pop_front()));
      prev_gnt = gnt_o;
    end
    chk("t3_all_grants_seen", 32'(exp_q.size()), 32'd0);

    // Wrap-around: last owner 14, then requesters 0 and 1.
    step(1'b1, 16'h0000, 1'b0);
    step(1'b0, 16'h4000, 1'b0);
    chk("t4_gnt14", 32'(gnt_o), 32'h4000);
    drain();
    step(1'b0, 16'h0003, 1'b0);
    chk("t4_wrap_gnt0", 32'(gnt_o), 32'h0001);
    step(1'b0, 16'h0003, 1'b1);
    step(1'b0, 16'h0003, 1'b0);
    step(1'b0, 16'h0003, 1'b0);
    chk("t4_next_gnt1", 32'(gnt_o), 32'h0002);

    // Owner 5 drops its request; 9 takes over; reset mid-grant drops it without a gap.
    drain();
    step(1'b0, 16'h0220, 1'b0);
    chk("t5_gnt5", 32'(gnt_o), 32'h0020);
    step(1'b0, 16'h0200, 1'b0);
    chk("t5_drop_busy", 32'(busy_o), 32'h1);
    step(1'b0, 16'h0200, 1'b0);
    step(1'b0, 16'h0200, 1'b0);
    chk("t5_gnt9", 32'(gnt_o), 32'h0200);
    step(1'b1, 16'h0200, 1'b0);
    chk("t5_rst_gnt", 32'(gnt_o), 32'h0);
    chk("t5_rst_busy", 32'(busy_o), 32'h0);

    // Long hold with no release.
    held = 0; to_cnt = 0;
`ifdef MUX_ARB_TIMEOUT_EN
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 16'h0010, 1'b0);
      if (gnt_o == 16'h0010) held++;
      if (timeout_o) to_cnt++;
    end
    chk("t6_hold_len", 32'(held), 32'(HOLD));
    chk("t6_to_pulses", 32'(to_cnt), 32'd1);
    step(1'b0, 16'h0010, 1'b0);
    chk("t6_regrant", 32'(gnt_o), 32'h0010);
`else
    for (int i = 0; i < 110; i++) begin
      step(1'b0, 16'h0010, 1'b0);
      if (gnt_o == 16'h0010) held++;
      if (timeout_o) to_cnt++;
    end
    chk("t6_hold_len", 32'(held), 32'd110);
    chk("t6_to_pulses", 32'(to_cnt), 32'd0);
`endif

    // Random traffic against the model.
    step(1'b1, 16'h0000, 1'b0);
    rq = 16'h0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
      step(($urandom_range(0, 299) == 0), rq, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
